oddeven_sorter: RTL
===================

# oddeven_sorter

Sequential, parametrised sorter: loads COUNT unsigned WIDTH-bit elements in one cycle and sorts them in place by odd-even transposition, one compare-exchange phase per clock. It is the clocked, generalised successor to the fixed 4×4-bit combinational sorting network. It trades latency for area (COUNT/2 comparators instead of a full network) and adds a start/ready/done handshake and a runtime ascending/descending mode.

## Interface
Parameters:
- WIDTH, 4, bits per element (≥1)
- COUNT, 4, number of elements (≥2)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- nrst  in  1  reset; asynchronous, active-low
- start  in  1  request to load din and begin sorting; sampled only while ready=1
- desc  in  1  sort order, captured with din: 0 = ascending, 1 = descending
- din  in  COUNT*WIDTH  element i = din[i*WIDTH +: WIDTH]
- ready  out  1  1 in IDLE and DONE; combinational from state
- done  out  1  one-cycle pulse: dout holds a sorted result
- dout  out  COUNT*WIDTH  element i = dout[i*WIDTH +: WIDTH]; driven directly from the working registers

## Operation
- States are IDLE, SORT and DONE.
- Transitions:
  - IDLE/DONE → SORT on start=1: capture din and desc, clear the phase counter.
  - DONE → IDLE when start=0.
  - SORT → DONE after the final phase.
  - start during SORT is ignored; no abort.
- Phase p (0-based) does compare-exchange on adjacent pairs:
  - p even: pairs (0,1),(2,3),…
  - p odd: pairs (1,2),(3,4),…
  - Odd COUNT leaves the last element (even phase) or element 0 (odd phase) unpaired; unpaired elements are unchanged.
- Ordering rule:
  - Ascending: after the sort, element 0 holds the minimum.
  - Descending: element 0 holds the maximum.
  - Comparison is unsigned, full WIDTH.
  - Swap only on strict inequality, so equal values never swap (stable).
- Without early exit, exactly COUNT phases run. This is sufficient for any input.
- dout holds the last sorted result until the next accepted start. It then shows intermediate contents during SORT.
- Phase counter width is $clog2(COUNT+1). No overflow is possible.

## Timing
- Reset (nrst low, asynchronous): state=IDLE, phase=0, working registers=0, dout=0, done=0, ready=1. Asserting reset mid-SORT aborts immediately; no done pulse is issued.
- Start accepted at edge E: phase 0 result visible after E+1, phase k after E+1+k.
- Without early exit, done=1 during the cycle after edge E+COUNT, i.e. the latency is COUNT cycles from the accept edge to the done cycle.
- done lasts exactly one cycle, the cycle spent in DONE. If start=1 in that cycle, the next sort is accepted (back-to-back, no bubble) and done falls.
- desc changes after the accept edge have no effect on the sort in progress.

## Configuration
- Macro: ODDEVEN_SORTER_EARLY_EXIT_EN.
- Defined:
  - A register records whether the previous phase swapped.
  - If phase p≥1 performs no swap and phase p−1 performed no swap, SORT → DONE after phase p. Latency is then p+1 cycles, with a minimum of 2.
  - An already-sorted input finishes in 2 cycles.
  - The COUNT-phase upper bound still applies.
- Not defined: no swap tracking; always COUNT phases. Outputs are identical in both builds; only latency differs.

## Test plan
Element lists are given index 0 first; WIDTH=4, COUNT=4 unless noted.
- Reset: nrst=0 mid-SORT → ready=1, done=0, dout=0 immediately. No done pulse follows release.
- Ascending: din {3,1,2,0}, desc=0 → done in cycle after E+4, dout {0,1,2,3}. Without the macro, latency is exactly 4.
- Descending with ties: din {5,F,5,0}, desc=1 → dout {F,5,5,0}. Equal elements never swap; check via per-phase dout.
- Back-to-back: start held high → second input {9,8,7,6} accepted in the done cycle → dout {6,7,8,9} four cycles later. start during SORT is ignored.
- Early exit (macro defined): din {0,1,2,3}, desc=0 → done after 2 cycles, dout unchanged. Without the macro → 4 cycles.
- Odd count: COUNT=5, WIDTH=8, din {FF,00,80,7F,01} ascending → dout {00,01,7F,80,FF} after ≤5 cycles. Also run a random sweep against a reference sort, both orders.

Source files
------------

// File: rtl/oddeven_sorter.sv
// oddeven_sorter: clocked odd-even transposition sorter, one compare-exchange phase per cycle.
// Define ODDEVEN_SORTER_EARLY_EXIT_EN to finish after two consecutive swap-free phases.
module oddeven_sorter #(
  parameter int WIDTH = 4,
  parameter int COUNT = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start,
  input  logic                   desc,
  input  logic [COUNT*WIDTH-1:0] din,
  output logic                   ready,
  output logic                   done,
  output logic [COUNT*WIDTH-1:0] dout
);

  localparam int          PW      = $clog2(COUNT + 1);
  localparam int unsigned COUNT_U = COUNT;

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t                      state_q, state_d;
  logic [PW-1:0]               phase_q, phase_d;
  logic                        desc_q, desc_d;
  logic [COUNT-1:0][WIDTH-1:0] elems_q, elems_d, phased;
  logic                        any_swap;
`ifdef ODDEVEN_SORTER_EARLY_EXIT_EN
  logic                        swapped_q, swapped_d;
`endif

  // Pairs start at even indices on even phases and odd indices on odd phases, so they never overlap.
  always_comb begin : exchange
    phased   = elems_q;
    any_swap = 1'b0;
    for (int unsigned i = 0; i < COUNT_U - 1; i++) begin
      if (i[0] == phase_q[0]) begin
        if (desc_q ? (elems_q[i] < elems_q[i+1]) : (elems_q[i] > elems_q[i+1])) begin
          phased[i]   = elems_q[i+1];
          phased[i+1] = elems_q[i];
          any_swap    = 1'b1;
        end
      end
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    phase_d   = phase_q;
    desc_d    = desc_q;
    elems_d   = elems_q;
`ifdef ODDEVEN_SORTER_EARLY_EXIT_EN
    swapped_d = swapped_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = SORT;
          elems_d   = din;
          desc_d    = desc;
          phase_d   = '0;
`ifdef ODDEVEN_SORTER_EARLY_EXIT_EN
          swapped_d = 1'b0;
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SORT: begin
        elems_d = phased;
        phase_d = phase_q + PW'(1);
`ifdef ODDEVEN_SORTER_EARLY_EXIT_EN
        swapped_d = any_swap;
        if (phase_q == PW'(COUNT - 1)) begin
          state_d = DONE;
        end else if ((phase_q != '0) && !any_swap && !swapped_q) begin
          state_d = DONE;
        end
`else
        if (phase_q == PW'(COUNT - 1)) begin
          state_d = DONE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      desc_q    <= 1'b0;
      elems_q   <= '0;
`ifdef ODDEVEN_SORTER_EARLY_EXIT_EN
      swapped_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      desc_q    <= desc_d;
      elems_q   <= elems_d;
`ifdef ODDEVEN_SORTER_EARLY_EXIT_EN
      swapped_q <= swapped_d;
`endif
    end
  end

  assign ready = (state_q == IDLE) || (state_q == DONE);
  assign done  = (state_q == DONE);
  assign dout  = elems_q;

endmodule
